// File: rtl/hsync_timing_generator.sv
// Parametrised horizontal timing generator: clock divider, ACTIVE/FRONT/SYNC/BACK
// segment FSM and pixel replication, with all outputs registered one clk behind the FSM.
module hsync_timing_generator #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int SYNC_POL  = 0,
  parameter int CLK_DIV   = 2,
  parameter int PIXEL_REP = 5,
  parameter int HPIX_W    = 7
) (
  input  logic              clk,
  input  logic              reset,
  output logic [HPIX_W-1:0] hpixel,
  output logic              hsync,
  output logic              en,
  output logic              pix_tick,
  output logic              line_end
);

  localparam int NCOL    = (H_ACTIVE + PIXEL_REP - 1) / PIXEL_REP;
  localparam int SEG_MAX = (H_ACTIVE > H_FRONT ? H_ACTIVE : H_FRONT) > (H_SYNC > H_BACK ? H_SYNC : H_BACK)
                         ? (H_ACTIVE > H_FRONT ? H_ACTIVE : H_FRONT) : (H_SYNC > H_BACK ? H_SYNC : H_BACK);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SEG_W   = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;
  localparam int REP_W   = (PIXEL_REP > 1) ? $clog2(PIXEL_REP) : 1;
  localparam logic SPOL  = (SYNC_POL != 0);

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 || CLK_DIV < 1 || PIXEL_REP < 1
      || longint'(NCOL) > (longint'(1) << HPIX_W)) begin : g_illegal
    $fatal(1, "hsync_timing_generator: illegal parameter set");
  end

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [SEG_W-1:0]  seg_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic [HPIX_W-1:0] col;
  logic              tick;
  logic              seg_last;
  logic              rep_last;
  state_t            state_nxt;

  assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rep_last = (rep_cnt == REP_W'(PIXEL_REP - 1));

  always_comb begin
    seg_last  = 1'b0;
    state_nxt = ACTIVE;
    unique case (state)
      ACTIVE: begin seg_last = (seg_cnt == SEG_W'(H_ACTIVE - 1)); state_nxt = FRONT;  end
      FRONT:  begin seg_last = (seg_cnt == SEG_W'(H_FRONT - 1));  state_nxt = SYNC;   end
      SYNC:   begin seg_last = (seg_cnt == SEG_W'(H_SYNC - 1));   state_nxt = BACK;   end
      BACK:   begin seg_last = (seg_cnt == SEG_W'(H_BACK - 1));   state_nxt = ACTIVE; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ACTIVE;
      div_cnt  <= '0;
      seg_cnt  <= '0;
      rep_cnt  <= '0;
      col      <= '0;
      hpixel   <= '0;
      hsync    <= ~SPOL;
      en       <= 1'b0;
      pix_tick <= 1'b0;
      line_end <= 1'b0;
    end else begin
      div_cnt  <= tick ? '0 : div_cnt + 1'b1;

      // Outputs sample the pre-edge state, so they trail the FSM by one clk.
      en       <= (state == ACTIVE);
      hsync    <= (state == SYNC) ? SPOL : ~SPOL;
      hpixel   <= col;
      pix_tick <= tick;
      line_end <= tick && (state == BACK) && seg_last;

      if (tick) begin
        if (seg_last) begin
          state   <= state_nxt;
          seg_cnt <= '0;
        end else begin
          seg_cnt <= seg_cnt + 1'b1;
        end

        if (state == ACTIVE) begin
          if (seg_last) begin
            rep_cnt <= '0;
            col     <= '0;
          end else if (rep_last) begin
            rep_cnt <= '0;
            col     <= col + 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/hsync_timing_generator.md
Name: hsync_timing_generator

Overview:
- Parametrised horizontal timing generator; next generation of the fixed-timing hsync generator.
- Produces hsync, display enable, a replicated pixel column index, a pixel-tick strobe and an end-of-line pulse from the system clock.
- Timing segments, sync polarity, clock-to-pixel divide and pixel replication are set by parameters; defaults give 640x(VGA) line timing at a 50 MHz clk with 128 logical columns.
- Feeds the vertical timing generator (line_end, pix_tick) and the pixel fetch path (hpixel, en).

Parameters:
- H_ACTIVE, 640, visible pixel ticks per line
- H_FRONT, 16, front-porch pixel ticks
- H_SYNC, 96, sync-pulse pixel ticks
- H_BACK, 48, back-porch pixel ticks
- SYNC_POL, 0, asserted level of hsync (0 = active-low)
- CLK_DIV, 2, clk cycles per pixel tick (1 = tick every clk)
- PIXEL_REP, 5, pixel ticks per hpixel increment
- HPIX_W, 7, width of hpixel

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- hpixel  output  HPIX_W  logical column index during active video
- hsync  output  1  horizontal sync, asserted at SYNC_POL
- en  output  1  display enable, high during active video
- pix_tick  output  1  one-clk strobe per pixel tick
- line_end  output  1  one-clk pulse at end of each line

Behaviour:
- Legality (elaboration check, fatal): all segment lengths >= 1, CLK_DIV >= 1, PIXEL_REP >= 1, ceil(H_ACTIVE/PIXEL_REP) <= 2^HPIX_W.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. Internal tick is true when div_cnt == CLK_DIV-1. CLK_DIV=1 gives tick every clk.
- FSM states ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, with segment counter seg_cnt.
  - On tick: if seg_cnt == len(state)-1, advance state and clear seg_cnt; else increment seg_cnt.
  - No advance without a tick.
- Replication: rep_cnt and col advance on tick in ACTIVE only.
  - rep_cnt == PIXEL_REP-1 gives rep_cnt=0 and col+1; otherwise rep_cnt+1.
  - col and rep_cnt are forced to 0 on the tick that leaves ACTIVE.
  - If H_ACTIVE is not a multiple of PIXEL_REP, the last column is truncated.
- Outputs: all registered and loaded every clk from the current (pre-edge) state, so they lag the FSM by one clk.
  - en <= (state==ACTIVE)
  - hsync <= (state==SYNC) ? SYNC_POL : ~SYNC_POL
  - hpixel <= col
  - pix_tick <= tick
  - line_end <= tick & state==BACK & seg_cnt==H_BACK-1
- Line period: (H_ACTIVE+H_FRONT+H_SYNC+H_BACK)*CLK_DIV clks, exactly.
- Reset (reset=0, asynchronous):
  - Internal: state=ACTIVE, div_cnt=0, seg_cnt=0, rep_cnt=0, col=0.
  - Outputs: hpixel=0, hsync=~SYNC_POL, en=0, pix_tick=0, line_end=0, all immediately with no clk edge.
  - Asserting reset mid-line aborts the line; no line_end is emitted.
- After release: first clk edge sets en=1. First tick occurs at the CLK_DIV-th edge. The line starts at ACTIVE column 0.
- Wrap-around: col never exceeds ceil(H_ACTIVE/PIXEL_REP)-1; counters never overflow. line_end and the ACTIVE re-entry happen on the same tick.

Test Plan:
- Reset held low 10 clks, then released -> during reset: hsync=1, en=0, hpixel=0, pix_tick=0, line_end=0. en=1 after first edge. pix_tick first high after the 2nd edge.
- Defaults, 3 full lines:
  - line_end pulses exactly every 1600 clks, each pulse 1 clk wide.
  - en high 1280 consecutive clks per line.
  - hsync low 192 clks per line, starting 1312 clks after en rises.
- Defaults, hpixel:
  - Steps 0..127; each value held 10 clks while en=1.
  - Reads 0 on the clk en falls and stays 0 through the blanking interval.
- Overrides H_ACTIVE=8, H_FRONT=2, H_SYNC=3, H_BACK=1, CLK_DIV=1, PIXEL_REP=1, SYNC_POL=1, HPIX_W=3:
  - Period 14 clks; pix_tick constant 1 after the first edge.
  - hpixel 0..7 in one clk each; hsync high for 3 clks.
- Async reset pulse of 3 ns inside the SYNC segment, asynchronous to clk -> outputs return to reset values before the next clk edge, with no line_end. After release, en rises on the next edge and hpixel restarts at 0.
- Overrides H_ACTIVE=10, PIXEL_REP=4 -> hpixel sequence 0,0,0,0,1,1,1,1,2,2 per tick, then 0 in FRONT.
